// File: rtl/scan_dff_bank_if.sv
// Bus bundle for scan_dff_bank: functional D/Q path plus the scan engine signals.
// par_err exists only when SCAN_DFF_BANK_PARITY_EN is defined.
interface scan_dff_bank_if #(
    parameter int WIDTH  = 19,
    parameter int CHAINS = 1
);
    logic [WIDTH-1:0]  D;
    logic              en;
    logic [WIDTH-1:0]  Q;
    logic              scan_req;
    logic [CHAINS-1:0] scan_in;
    logic [CHAINS-1:0] scan_out;
    logic              scan_busy;
    logic              scan_done;
`ifdef SCAN_DFF_BANK_PARITY_EN
    logic              par_err;

    modport master (
        output D, en, scan_req, scan_in,
        input  Q, scan_out, scan_busy, scan_done, par_err
    );

    modport slave (
        input  D, en, scan_req, scan_in,
        output Q, scan_out, scan_busy, scan_done, par_err
    );
`else
    modport master (
        output D, en, scan_req, scan_in,
        input  Q, scan_out, scan_busy, scan_done
    );

    modport slave (
        input  D, en, scan_req, scan_in,
        output Q, scan_out, scan_busy, scan_done
    );
`endif
endinterface

// File: rtl/scan_dff_bank.sv
// State-register bank with functional capture and CHAINS parallel scan chains shifted by a small FSM.
// Optional parity tracking with a registered par_err flag when SCAN_DFF_BANK_PARITY_EN is defined.
module scan_dff_bank #(
    parameter int               WIDTH     = 19,
    parameter int               CHAINS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic           CK,
    input  logic           RST,
    scan_dff_bank_if.slave bus
);
    localparam int LEN = WIDTH / CHAINS;
    localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  shift_s;
    logic [CHAINS-1:0] scan_out_s;
    logic              busy_s;
    logic              done_s;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Each chain takes scan_in at its low bit and presents its top bit on scan_out (MSB first).
    for (genvar c = 0; c < CHAINS; c++) begin : g_chain
        assign shift_s[c*LEN] = bus.scan_in[c];
        for (genvar i = 1; i < LEN; i++) begin : g_bit
            assign shift_s[c*LEN+i] = q_q[c*LEN+i-1];
        end
        assign scan_out_s[c] = q_q[c*LEN+LEN-1];
    end

    // State register: FSM state, shift counter and the state bits themselves.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            q_q     <= RESET_VAL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // Next-state logic: a scan request in IDLE takes priority over functional capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.scan_req) begin
                    state_d = ST_SHIFT;
                    cnt_d   = {CW{1'b0}};
                end else if (bus.en) begin
                    q_d = bus.D;
                end else begin
                    q_d = q_q;
                end
            end
            ST_SHIFT: begin
                q_d = shift_s;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_IDLE:  begin busy_s = 1'b0; done_s = 1'b0; end
            ST_SHIFT: begin busy_s = 1'b1; done_s = 1'b0; end
            ST_DONE:  begin busy_s = 1'b0; done_s = 1'b1; end
            default:  begin busy_s = 1'b0; done_s = 1'b0; end
        endcase
    end

    assign bus.Q         = q_q;
    assign bus.scan_out  = scan_out_s;
    assign bus.scan_busy = busy_s;
    assign bus.scan_done = done_s;

`ifdef SCAN_DFF_BANK_PARITY_EN
    logic p_q, p_d;
    logic par_err_q, par_err_d;

    // Parity follows every legitimate write of Q; the check is only meaningful while idle.
    always_comb begin
        p_d = p_q;
        if ((state_q == ST_IDLE) && !bus.scan_req && bus.en) begin
            p_d = parity_f(bus.D);
        end else if ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST)) begin
            p_d = parity_f(shift_s);
        end else begin
            p_d = p_q;
        end
        if (state_q == ST_IDLE) begin
            par_err_d = (parity_f(q_q) != p_q);
        end else begin
            par_err_d = 1'b0;
        end
    end

    // Parity bit and error flag registers.
    always_ff @(posedge CK) begin
        if (RST) begin
            p_q       <= parity_f(RESET_VAL);
            par_err_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            par_err_q <= par_err_d;
        end
    end

    assign bus.par_err = par_err_q;
`endif
endmodule

// File: tb/tb_scan_dff_bank.sv
// Scoreboard bench for scan_dff_bank: an 8-bit two-chain bank and a 19-bit single-chain bank.
// Expected scan_out bits and post-pass Q values are queued by the stimulus and popped by a monitor.
module tb_scan_dff_bank;
    logic CK;
    logic rst8, rst19;
    int   checks   = 0;
    int   failures = 0;

    logic [1:0]  exp_so8[$];
    logic [7:0]  exp_q8[$];
    logic        exp_so19[$];
    logic [18:0] exp_q19[$];

    int   busy_n, done_at, done_n;
    int   nd, hi_run, lo_run;
    int   dt[4];
    logic prev_busy;

    scan_dff_bank_if #(.WIDTH(8),  .CHAINS(2)) b8();
    scan_dff_bank_if #(.WIDTH(19), .CHAINS(1)) b19();

    scan_dff_bank #(.WIDTH(8), .CHAINS(2), .RESET_VAL(8'h3C)) u8 (
        .CK(CK), .RST(rst8), .bus(b8)
    );
    scan_dff_bank #(.WIDTH(19), .CHAINS(1), .RESET_VAL(19'h0)) u19 (
        .CK(CK), .RST(rst19), .bus(b19)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic watch8(input int ncyc, output int bn, output int da, output int dn);
        bn = 0; da = 0; dn = 0;
        for (int n = 1; n <= ncyc; n++) begin
            if (b8.scan_busy === 1'b1) bn++;
            if (b8.scan_done === 1'b1) begin
                dn++;
                if (da == 0) da = n;
            end
            tick();
        end
    endtask

    // Monitor: pop and compare whenever a bank presents a scan bit or a completed pass.
    always @(negedge CK) begin
        if (b8.scan_busy === 1'b1) begin
            if (exp_so8.size() == 0) begin
                checks++; failures++;
                $display("FAIL so8_unexpected actual=%0h required=none", b8.scan_out);
            end else check("so8", 32'(b8.scan_out), 32'(exp_so8.pop_front()));
        end
        if (b8.scan_done === 1'b1) begin
            if (exp_q8.size() == 0) begin
                checks++; failures++;
                $display("FAIL done8_unexpected actual=%0h required=none", b8.Q);
            end else check("done_q8", 32'(b8.Q), 32'(exp_q8.pop_front()));
        end
        if (b19.scan_busy === 1'b1) begin
            if (exp_so19.size() == 0) begin
                checks++; failures++;
                $display("FAIL so19_unexpected actual=%0h required=none", b19.scan_out);
            end else check("so19", 32'(b19.scan_out), 32'(exp_so19.pop_front()));
        end
        if (b19.scan_done === 1'b1) begin
            if (exp_q19.size() == 0) begin
                checks++; failures++;
                $display("FAIL done19_unexpected actual=%0h required=none", b19.Q);
            end else check("done_q19", 32'(b19.Q), 32'(exp_q19.pop_front()));
        end
    end

    initial begin
        rst8 = 1'b1; rst19 = 1'b1;
        b8.en = 1'b1;  b8.D = 8'hFF;   b8.scan_req = 1'b0;  b8.scan_in = 2'b00;
        b19.en = 1'b0; b19.D = 19'h0;  b19.scan_req = 1'b0; b19.scan_in = 1'b0;

        // Reset held two edges with capture requested: reset must win.
        tick(); tick();
        check("rst_q8", 32'(b8.Q), 32'h3C);
        check("rst_busy8", 32'(b8.scan_busy), 32'h0);
        check("rst_done8", 32'(b8.scan_done), 32'h0);
        check("rst_q19", 32'(b19.Q), 32'h0);
        rst8 = 1'b0; rst19 = 1'b0;
        b8.D = 8'h5A;
        tick();
        check("cap_5a", 32'(b8.Q), 32'h5A);

        // Two-chain unload of A5 with ones shifted in.
        b8.D = 8'hA5;
        tick();
        check("cap_a5", 32'(b8.Q), 32'hA5);
        b8.en = 1'b0; b8.scan_in = 2'b11;
        exp_so8.push_back(2'b10); exp_so8.push_back(2'b01);
        exp_so8.push_back(2'b10); exp_so8.push_back(2'b01);
        exp_q8.push_back(8'hFF);
        b8.scan_req = 1'b1;
        tick();
        b8.scan_req = 1'b0;
        watch8(8, busy_n, done_at, done_n);
        check("p1_busy_len", 32'(busy_n), 32'd4);
        check("p1_done_at", 32'(done_at), 32'd5);
        check("p1_done_cnt", 32'(done_n), 32'd1);

        // Capture requested throughout a pass: ignored until the first IDLE edge.
        b8.en = 1'b1; b8.D = 8'h00; b8.scan_in = 2'b01; b8.scan_req = 1'b1;
        for (int k = 0; k < 4; k++) exp_so8.push_back(2'b11);
        exp_q8.push_back(8'h0F);
        tick();
        check("req_beats_en", 32'(b8.Q), 32'hFF);
        b8.scan_req = 1'b0;
        watch8(5, busy_n, done_at, done_n);
        check("p2_busy_len", 32'(busy_n), 32'd4);
        check("p2_done_at", 32'(done_at), 32'd5);
        check("idle_first_q", 32'(b8.Q), 32'h0F);
        tick();
        check("idle_capture", 32'(b8.Q), 32'h00);

        // Reset during SHIFT cycle 2 aborts the pass; a fresh pass then runs in full.
        b8.D = 8'hA5;
        tick();
        b8.en = 1'b0; b8.scan_in = 2'b00;
        exp_so8.push_back(2'b10); exp_so8.push_back(2'b01); exp_so8.push_back(2'b10);
        b8.scan_req = 1'b1;
        tick();
        b8.scan_req = 1'b0;
        tick(); tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("abort_q", 32'(b8.Q), 32'h3C);
        check("abort_busy", 32'(b8.scan_busy), 32'h0);
        watch8(8, busy_n, done_at, done_n);
        check("abort_no_done", 32'(done_n), 32'd0);
        check("abort_no_busy", 32'(busy_n), 32'd0);
        b8.scan_in = 2'b10;
        exp_so8.push_back(2'b01); exp_so8.push_back(2'b01);
        exp_so8.push_back(2'b10); exp_so8.push_back(2'b10);
        exp_q8.push_back(8'hF0);
        b8.scan_req = 1'b1;
        tick();
        b8.scan_req = 1'b0;
        watch8(8, busy_n, done_at, done_n);
        check("p3_busy_len", 32'(busy_n), 32'd4);
        check("p3_done_at", 32'(done_at), 32'd5);
        check("p3_done_cnt", 32'(done_n), 32'd1);

`ifdef SCAN_DFF_BANK_PARITY_EN
        // Parity: a bit flipped behind the bank's back is flagged one cycle later.
        b8.en = 1'b1; b8.D = 8'h01;
        tick();
        b8.en = 1'b0;
        tick();
        check("par_clean", 32'(b8.par_err), 32'h0);
        force u8.q_q = 8'h09;
        tick();
        release u8.q_q;
        check("par_fault", 32'(b8.par_err), 32'h1);
        b8.scan_in = 2'b00;
        exp_so8.push_back(2'b01); exp_so8.push_back(2'b00);
        exp_so8.push_back(2'b00); exp_so8.push_back(2'b01);
        exp_q8.push_back(8'h00);
        b8.scan_req = 1'b1;
        tick();
        b8.scan_req = 1'b0;
        watch8(8, busy_n, done_at, done_n);
        check("par_pass_done", 32'(done_n), 32'd1);
        check("par_after_scan", 32'(b8.par_err), 32'h0);
`endif

        // Continuous scan_req on the 19-bit single chain: period LEN+2.
        b19.scan_in = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 19; k++) exp_so19.push_back((p == 0) ? 1'b0 : 1'b1);
            exp_q19.push_back(19'h7FFFF);
        end
        b19.scan_req = 1'b1;
        tick();
        nd = 0; hi_run = 0; lo_run = 0; prev_busy = 1'b1;
        for (int n = 1; n <= 66; n++) begin
            if (b19.scan_done === 1'b1) begin
                if (nd < 4) dt[nd] = n;
                nd++;
            end
            if (b19.scan_busy === 1'b1) begin
                if (!prev_busy) check("busy19_gap", 32'(lo_run), 32'd2);
                hi_run++; lo_run = 0;
            end else begin
                if (prev_busy) check("busy19_len", 32'(hi_run), 32'd19);
                lo_run++; hi_run = 0;
            end
            prev_busy = b19.scan_busy;
            tick();
        end
        check("done19_count", 32'(nd), 32'd3);
        if (nd >= 3) begin
            check("done19_first", 32'(dt[0]), 32'd20);
            check("done19_period_a", 32'(dt[1] - dt[0]), 32'd21);
            check("done19_period_b", 32'(dt[2] - dt[1]), 32'd21);
        end
        b19.scan_req = 1'b0;
        for (int k = 0; k < 25; k++) tick();

        check("so8_left", 32'(exp_so8.size()), 32'd0);
        check("q8_left", 32'(exp_q8.size()), 32'd0);
        check("so19_left", 32'(exp_so19.size()), 32'd0);
        check("q19_left", 32'(exp_q19.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scan_dff_bank.md
Name: scan_dff_bank

Overview:
- Parametrised state-register bank that replaces the per-bit dff instances in the sequential benchmark netlists.
- Holds WIDTH state bits with functional capture and synchronous reset to a programmable value.
- Adds a built-in scan engine. The bits split into CHAINS equal scan chains that a small FSM shifts for a fixed count, so the full state can be loaded and unloaded for key/state extraction and test.
- Instantiated once per benchmark top; the benchmark's next-state logic feeds D and reads Q.

Parameters:
- WIDTH, 19, number of state bits; must be a multiple of CHAINS.
- CHAINS, 1, number of parallel scan chains. Chain length LEN = WIDTH/CHAINS.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- D  input  WIDTH  functional next-state vector.
- en  input  1  functional capture enable.
- Q  output  WIDTH  registered state.
- scan_req  input  1  request one full scan pass; sampled in IDLE only.
- scan_in  input  CHAINS  serial input, one bit per chain.
- scan_out  output  CHAINS  serial output, one bit per chain.
- scan_busy  output  1  high while in SHIFT.
- scan_done  output  1  one-cycle pulse in DONE.

Behaviour:
- Chain c owns bits Q[c*LEN +: LEN].
  - Shift: Q[c*LEN] <= scan_in[c]; Q[c*LEN+i] <= Q[c*LEN+i-1] for i = 1..LEN-1.
  - scan_out[c] = Q[c*LEN+LEN-1], combinational from the register, valid in every state.
- Reset (RST=1 at edge, overrides everything):
  - Q <= RESET_VAL, state <= IDLE, shift counter <= 0.
  - scan_busy = 0, scan_done = 0.
  - Reset mid-SHIFT aborts the pass. No scan_done is issued and the partially shifted contents are discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, scan_req=1: go to SHIFT, counter <= 0, Q unchanged this edge (scan_req wins over en).
  - IDLE, scan_req=0, en=1: Q <= D.
  - IDLE, scan_req=0, en=0: Q holds.
  - SHIFT: every edge shifts all chains by one and increments the counter. After the LEN-th shift (counter == LEN-1 at the edge), go to DONE. en and D are ignored. scan_req is ignored.
  - DONE: Q holds. Always returns to IDLE next edge. scan_req and en are ignored in DONE.
- Timing: scan_req sampled at edge t → SHIFT occupies cycles t+1..t+LEN → DONE at cycle t+LEN+1 → IDLE at t+LEN+2.
- scan_out[c] in SHIFT cycle k (k = 0..LEN-1) equals the original bit Q[c*LEN+LEN-1-k], i.e. MSB first.
- scan_busy is high exactly LEN cycles; scan_done is high exactly one cycle.
- The counter is $clog2(LEN) bits wide (minimum 1). LEN=1 gives a single SHIFT cycle.
- Back-to-back passes: a scan_req held high through DONE starts the next pass only when sampled in IDLE. Minimum period is LEN+2 cycles.

Optional Feature:
- Macro: SCAN_DFF_BANK_PARITY_EN.
- When defined:
  - Extra output par_err (1 bit) and an internal parity bit p.
  - p <= ^D on each functional capture; p <= ^RESET_VAL on reset; p <= ^Q_next on the final shift edge.
  - par_err = (^Q != p) in IDLE, forced to 0 in SHIFT/DONE; registered, so it is reported one cycle later.
  - A fault injected into Q while in IDLE raises par_err on the following cycle.
- When undefined: no par_err port, no parity logic; behaviour otherwise identical.

Test Plan:
- WIDTH=8, RESET_VAL=8'h3C: assert RST two cycles with en=1, D=8'hFF → Q=8'h3C, scan_busy=0, scan_done=0. Then RST=0, en=1, D=8'h5A → Q=8'h5A next cycle.
- WIDTH=8, CHAINS=2, Q=8'hA5, scan_req pulse, scan_in=2'b11 held:
  - scan_out sequence across SHIFT cycles 0..3 is {1,0}, {0,1}, {1,0}, {0,1} (chain1, chain0).
  - scan_busy high 4 cycles, scan_done at cycle 5, final Q=8'hFF.
- Same config, en=1, D=8'h00 held throughout a scan → Q unaffected during SHIFT/DONE. Q=8'h00 only on the first IDLE edge after DONE.
- RST asserted on SHIFT cycle 2 of a 4-cycle pass → Q=RESET_VAL, scan_done never pulses, next scan_req starts a fresh full pass.
- scan_req held high continuously, WIDTH=19, CHAINS=1 → scan_done pulses every 21 cycles; scan_busy low for exactly 2 cycles between passes.
- With SCAN_DFF_BANK_PARITY_EN: capture D=8'h01, then force Q[3] via testbench → par_err=1 next cycle. After a clean scan pass, par_err=0.
